hex_entry: RTL and testbench
============================

# hex_entry

Hex value entry controller downstream of the button trigger stage. Consumes single-cycle trigger pulses from the five front-panel buttons plus a clear button, edits a multi-nibble hex value (key or data block for the cipher core) under a cursor, and hands the finished value to the consumer with a valid/ready handshake. While a committed value awaits acceptance it drives `lock` back to the button stages so presses in that window are suppressed.

## Interface
- `NIB`, 16: number of hex nibbles in the value (value width `4*NIB`); legal range 2..16.
- `BLINK_CMAX`, 12_500_000: cursor blink half-period in clock cycles (250 ms at 50 MHz); minimum 2.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `tr_up`, `tr_down`, `tr_left`, `tr_right`, `tr_ok`, `tr_clr`  in  1 each  single-cycle trigger pulses from button stages.
- `value`  out  4*NIB  current value; nibble 0 = bits [3:0].
- `cursor`  out  $clog2(NIB)  index of the nibble under edit.
- `blink`  out  1  cursor-visible phase for the display driver.
- `o_valid`  out  1  committed value available on `value`.
- `i_ready`  in  1  consumer accepts value when high with `o_valid`.
- `lock`  out  1  to button stages; high while committed value is pending.

## Operation
- Two states: EDIT, COMMIT. Reset state EDIT.
- Reset values: `value`=0, `cursor`=0, `blink`=1, blink counter=0, `o_valid`=0, `lock`=0.
- EDIT, at most one trigger acted on per cycle, priority `tr_clr` > `tr_ok` > `tr_up` > `tr_down` > `tr_left` > `tr_right`; lower-priority pulses in the same cycle are dropped, not queued.
  - `tr_clr`: `value`=0, `cursor`=0.
  - `tr_ok`: go to COMMIT; `value` and `cursor` unchanged.
  - `tr_up`: nibble at `cursor` +1 mod 16 (F -> 0); other nibbles unchanged.
  - `tr_down`: nibble at `cursor` -1 mod 16 (0 -> F).
  - `tr_left`: `cursor` +1 toward MSB; `NIB-1` wraps to 0.
  - `tr_right`: `cursor` -1; 0 wraps to `NIB-1`.
- COMMIT: `o_valid`=1, `lock`=1, `value`/`cursor` frozen; all triggers ignored. On `o_valid && i_ready` return to EDIT.
- Blink: in EDIT a counter runs 0..`BLINK_CMAX-1`; at terminal count it wraps to 0 and `blink` toggles. Any acted-on `tr_up`/`tr_down`/`tr_left`/`tr_right`/`tr_clr` forces counter=0, `blink`=1 next cycle. In COMMIT counter held at 0, `blink` held at 1.
- All outputs registered; no combinational path from any input to any output.

## Timing
- Trigger acted on in cycle n -> `value`/`cursor`/`blink` updated from cycle n+1.
- `tr_ok` in cycle n -> `o_valid`=`lock`=1 from n+1.
- Handshake: transfer in cycle m (both high) -> `o_valid`=`lock`=0 from m+1; triggers in cycle m ignored; first editable trigger is in m+1.
- `i_ready` high before `o_valid` is legal; transfer occurs in the first cycle `o_valid` is high. `o_valid` never drops without a transfer except by reset.
- `rst` asserted mid-COMMIT or mid-edit: all state returns to reset values immediately (asynchronously); pending value is discarded, no transfer.
- Blink period: `blink` toggles every `BLINK_CMAX` cycles of uninterrupted EDIT.

## Test plan
- Bench `NIB`=16, `BLINK_CMAX`=4. Reset, pulse `tr_up` 3x, `tr_left`, `tr_up` 10x -> `value`=64'h0000_0000_0000_00A3, `cursor`=1.
- From reset: `tr_down` once -> `value`=64'h...000F; `tr_right` once -> `cursor`=15; `tr_left` once -> `cursor`=0.
- Same-cycle `tr_up`+`tr_left` -> only nibble increments, `cursor` unchanged; same-cycle `tr_clr`+`tr_ok` -> value cleared, stays in EDIT.
- `tr_ok` with `i_ready`=0 for 5 cycles, `tr_up` pulsed meanwhile -> `o_valid`=`lock`=1 throughout, `value` unchanged; raise `i_ready` -> one-cycle transfer, `o_valid`=`lock`=0 next cycle; `i_ready` held high before `tr_ok` -> `o_valid` high exactly one cycle.
- Idle in EDIT -> `blink` 1,1,1,1,0,0,0,0,1...; `tr_left` mid-low phase -> `blink`=1 next cycle, next toggle 4 cycles later.
- Assert `rst` asynchronously while in COMMIT with `value`=64'hDEAD_BEEF_0123_4567 -> `value`=0, `o_valid`=`lock`=0, `cursor`=0, `blink`=1 before next clock edge.

Source files
------------

// File: rtl/hex_entry.sv
// Hex value entry controller: edits a NIB-nibble value under a cursor from button
// trigger pulses and hands the committed value off with a valid/ready handshake.
module hex_entry #(
    parameter int NIB        = 16,
    parameter int BLINK_CMAX = 12_500_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tr_up,
    input  logic                    tr_down,
    input  logic                    tr_left,
    input  logic                    tr_right,
    input  logic                    tr_ok,
    input  logic                    tr_clr,
    output logic [4*NIB-1:0]        value,
    output logic [$clog2(NIB)-1:0]  cursor,
    output logic                    blink,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    lock
);

    localparam int CW = $clog2(NIB);
    localparam int BW = $clog2(BLINK_CMAX);

    // Handshake: o_valid holds until the cycle i_ready is also high (the transfer);
    // the value is stable and triggers are ignored from commit until after transfer.

    typedef enum logic {EDIT, COMMIT} state_t;

    state_t           state_q, state_d;
    logic [4*NIB-1:0] value_q, value_d;
    logic [CW-1:0]    cursor_q, cursor_d;
    logic [BW-1:0]    cnt_q, cnt_d;
    logic             blink_q, blink_d;
    logic             valid_q, valid_d;
    logic             lock_q, lock_d;

    logic [3:0]       nib_cur;
    logic [3:0]       nib_new;
    logic             restart;

    always_comb begin
        nib_cur = 4'd0;
        for (int i = 0; i < NIB; i++) begin
            if (CW'(i) == cursor_q) nib_cur = value_q[4*i +: 4];
        end
        nib_new = tr_up ? nib_cur + 4'd1 : nib_cur - 4'd1;
    end

    always_comb begin
        state_d  = state_q;
        value_d  = value_q;
        cursor_d = cursor_q;
        valid_d  = valid_q;
        lock_d   = lock_q;
        restart  = 1'b0;
        if (cnt_q == BW'(BLINK_CMAX - 1)) begin
            cnt_d   = '0;
            blink_d = ~blink_q;
        end else begin
            cnt_d   = cnt_q + BW'(1);
            blink_d = blink_q;
        end

        case (state_q)
            EDIT: begin
                // Only the highest-priority pulse is acted on; the rest are dropped.
                if (tr_clr) begin
                    value_d  = '0;
                    cursor_d = '0;
                    restart  = 1'b1;
                end else if (tr_ok) begin
                    state_d = COMMIT;
                    valid_d = 1'b1;
                    lock_d  = 1'b1;
                    restart = 1'b1;
                end else if (tr_up || tr_down) begin
                    for (int i = 0; i < NIB; i++) begin
                        if (CW'(i) == cursor_q) value_d[4*i +: 4] = nib_new;
                    end
                    restart = 1'b1;
                end else if (tr_left) begin
                    cursor_d = (cursor_q == CW'(NIB - 1)) ? '0 : cursor_q + CW'(1);
                    restart  = 1'b1;
                end else if (tr_right) begin
                    cursor_d = (cursor_q == '0) ? CW'(NIB - 1) : cursor_q - CW'(1);
                    restart  = 1'b1;
                end
            end
            COMMIT: begin
                restart = 1'b1;
                if (i_ready) begin
                    state_d = EDIT;
                    valid_d = 1'b0;
                    lock_d  = 1'b0;
                end
            end
            default: begin
                state_d = EDIT;
            end
        endcase

        if (restart) begin
            cnt_d   = '0;
            blink_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EDIT;
            value_q  <= '0;
            cursor_q <= '0;
            cnt_q    <= '0;
            blink_q  <= 1'b1;
            valid_q  <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            value_q  <= value_d;
            cursor_q <= cursor_d;
            cnt_q    <= cnt_d;
            blink_q  <= blink_d;
            valid_q  <= valid_d;
            lock_q   <= lock_d;
        end
    end

    assign value   = value_q;
    assign cursor  = cursor_q;
    assign blink   = blink_q;
    assign o_valid = valid_q;
    assign lock    = lock_q;

endmodule

// File: tb/tb_hex_entry.sv
// Directed bench for hex_entry: editing, trigger priority, handshake, blink timing
// and asynchronous reset, each step checked against hand-computed values.
module tb_hex_entry;

    localparam int NIB = 16;
    localparam int BLINK_CMAX = 4;

    localparam logic [5:0] B_CLR   = 6'b100000;
    localparam logic [5:0] B_OK    = 6'b010000;
    localparam logic [5:0] B_UP    = 6'b001000;
    localparam logic [5:0] B_DOWN  = 6'b000100;
    localparam logic [5:0] B_LEFT  = 6'b000010;
    localparam logic [5:0] B_RIGHT = 6'b000001;

    logic            clk;
    logic            rst;
    logic [5:0]      trig;
    logic            i_ready;
    logic [4*NIB-1:0] value;
    logic [3:0]      cursor;
    logic            blink;
    logic            o_valid;
    logic            lock;

    int n_checks;
    int n_fail;

    hex_entry #(.NIB(NIB), .BLINK_CMAX(BLINK_CMAX)) dut (
        .clk      (clk),
        .rst      (rst),
        .tr_up    (trig[3]),
        .tr_down  (trig[2]),
        .tr_left  (trig[1]),
        .tr_right (trig[0]),
        .tr_ok    (trig[4]),
        .tr_clr   (trig[5]),
        .value    (value),
        .cursor   (cursor),
        .blink    (blink),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .lock     (lock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Holds the trigger mask across one rising edge; returns at the next falling edge.
    task automatic press(input logic [5:0] m);
        trig = m;
        @(negedge clk);
        trig = '0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [63:0] target;
    logic [3:0]  nib;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        trig     = '0;
        i_ready  = 1'b0;
        target   = 64'hDEAD_BEEF_0123_4567;
        nib      = 4'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_value", value, 64'h0);
        check("rst_cursor", {60'h0, cursor}, 64'd0);
        check("rst_blink", {63'h0, blink}, 64'd1);
        check("rst_valid", {63'h0, o_valid}, 64'd0);
        check("rst_lock", {63'h0, lock}, 64'd0);

        // Basic editing: nibble 0 = 3, nibble 1 = A
        repeat (3) press(B_UP);
        press(B_LEFT);
        repeat (10) press(B_UP);
        check("edit_value", value, 64'h0000_0000_0000_00A3);
        check("edit_cursor", {60'h0, cursor}, 64'd1);

        // Wraparound of nibble and cursor
        press(B_CLR);
        check("clr_value", value, 64'h0);
        check("clr_cursor", {60'h0, cursor}, 64'd0);
        press(B_DOWN);
        check("down_wrap", value, 64'h0000_0000_0000_000F);
        press(B_RIGHT);
        check("right_wrap", {60'h0, cursor}, 64'd15);
        press(B_LEFT);
        check("left_wrap", {60'h0, cursor}, 64'd0);

        // Priority: up beats left, down beats left, clr beats ok
        press(B_UP | B_LEFT);
        check("up_left_value", value, 64'h0);
        check("up_left_cursor", {60'h0, cursor}, 64'd0);
        press(B_UP | B_LEFT);
        check("up_left_value2", value, 64'h1);
        press(B_DOWN | B_LEFT | B_RIGHT);
        check("down_left_value", value, 64'h0);
        check("down_left_cursor", {60'h0, cursor}, 64'd0);
        press(B_UP);
        press(B_CLR | B_OK);
        check("clr_ok_value", value, 64'h0);
        check("clr_ok_valid", {63'h0, o_valid}, 64'd0);
        check("clr_ok_lock", {63'h0, lock}, 64'd0);

        // Commit with consumer stalled; edits ignored
        press(B_UP);
        press(B_OK | B_UP);
        check("commit_valid", {63'h0, o_valid}, 64'd1);
        check("commit_lock", {63'h0, lock}, 64'd1);
        check("commit_value", value, 64'h1);
        for (int i = 0; i < 5; i++) begin
            press(B_UP);
            check("stall_valid", {63'h0, o_valid}, 64'd1);
            check("stall_lock", {63'h0, lock}, 64'd1);
            check("stall_value", value, 64'h1);
            check("stall_blink", {63'h0, blink}, 64'd1);
        end
        // Transfer cycle: trigger in the same cycle is ignored
        i_ready = 1'b1;
        press(B_UP);
        check("xfer_valid", {63'h0, o_valid}, 64'd0);
        check("xfer_lock", {63'h0, lock}, 64'd0);
        check("xfer_value", value, 64'h1);
        press(B_UP);
        check("post_xfer_edit", value, 64'h2);

        // Ready held high ahead of commit: valid for exactly one cycle
        press(B_OK);
        check("early_ready_valid", {63'h0, o_valid}, 64'd1);
        press('0);
        check("early_ready_drop", {63'h0, o_valid}, 64'd0);
        check("early_ready_lock", {63'h0, lock}, 64'd0);
        i_ready = 1'b0;

        // Blink: 4 high, 4 low, starting from a counter restart
        press(B_CLR);
        for (int k = 0; k < 14; k++) begin
            if (k != 0) press('0);
            check("blink_idle", {63'h0, blink}, ((k / 4) % 2 == 0) ? 64'd1 : 64'd0);
        end
        press(B_LEFT);
        check("blink_restart", {63'h0, blink}, 64'd1);
        for (int j = 1; j <= 4; j++) begin
            press('0);
            check("blink_after_restart", {63'h0, blink}, (j < 4) ? 64'd1 : 64'd0);
        end

        // Enter DEADBEEF01234567, commit, then reset asynchronously mid-cycle
        press(B_CLR);
        for (int i = 0; i < 16; i++) begin
            nib = target[4*i +: 4];
            if (nib <= 4'd8) begin
                for (int k = 0; k < int'(nib); k++) press(B_UP);
            end else begin
                for (int k = 0; k < 16 - int'(nib); k++) press(B_DOWN);
            end
            press(B_LEFT);
        end
        press(B_LEFT);
        check("long_value", value, 64'hDEAD_BEEF_0123_4567);
        check("long_cursor", {60'h0, cursor}, 64'd1);
        press(B_OK);
        check("long_commit", {63'h0, o_valid}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_value", value, 64'h0);
        check("arst_valid", {63'h0, o_valid}, 64'd0);
        check("arst_lock", {63'h0, lock}, 64'd0);
        check("arst_cursor", {60'h0, cursor}, 64'd0);
        check("arst_blink", {63'h0, blink}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
